// File: rtl/alu_seq_pkg.sv
// Shared definitions for the Hack ALU sequencer: opcodes, FSM states and
// the six-bit ALU control words {zx,nx,zy,ny,f,no}.
package alu_seq_pkg;

  localparam logic [3:0] OP_ZERO = 4'h0;
  localparam logic [3:0] OP_ONE  = 4'h1;
  localparam logic [3:0] OP_NEG1 = 4'h2;
  localparam logic [3:0] OP_X    = 4'h3;
  localparam logic [3:0] OP_Y    = 4'h4;
  localparam logic [3:0] OP_NOTX = 4'h5;
  localparam logic [3:0] OP_NEGX = 4'h6;
  localparam logic [3:0] OP_ADD  = 4'h7;
  localparam logic [3:0] OP_SUB  = 4'h8;
  localparam logic [3:0] OP_AND  = 4'h9;
  localparam logic [3:0] OP_OR   = 4'hA;
  localparam logic [3:0] OP_RSUB = 4'hB;
  localparam logic [3:0] OP_INCX = 4'hC;
  localparam logic [3:0] OP_MUL  = 4'hD;

  localparam logic [5:0] CW_ZERO = 6'b101010;
  localparam logic [5:0] CW_ONE  = 6'b111111;
  localparam logic [5:0] CW_NEG1 = 6'b111010;
  localparam logic [5:0] CW_X    = 6'b001100;
  localparam logic [5:0] CW_Y    = 6'b110000;
  localparam logic [5:0] CW_NOTX = 6'b001101;
  localparam logic [5:0] CW_NEGX = 6'b001111;
  localparam logic [5:0] CW_ADD  = 6'b000010;
  localparam logic [5:0] CW_SUB  = 6'b010011;
  localparam logic [5:0] CW_AND  = 6'b000000;
  localparam logic [5:0] CW_OR   = 6'b010101;
  localparam logic [5:0] CW_RSUB = 6'b000111;
  localparam logic [5:0] CW_INCX = 6'b011111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Opcodes without a single-pass control word fall back to constant zero.
  function automatic logic [5:0] op_ctrl(input logic [3:0] op);
    case (op)
      OP_ZERO: op_ctrl = CW_ZERO;
      OP_ONE:  op_ctrl = CW_ONE;
      OP_NEG1: op_ctrl = CW_NEG1;
      OP_X:    op_ctrl = CW_X;
      OP_Y:    op_ctrl = CW_Y;
      OP_NOTX: op_ctrl = CW_NOTX;
      OP_NEGX: op_ctrl = CW_NEGX;
      OP_ADD:  op_ctrl = CW_ADD;
      OP_SUB:  op_ctrl = CW_SUB;
      OP_AND:  op_ctrl = CW_AND;
      OP_OR:   op_ctrl = CW_OR;
      OP_RSUB: op_ctrl = CW_RSUB;
      OP_INCX: op_ctrl = CW_INCX;
      default: op_ctrl = CW_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decode to ALU control word plus legality.
// Opcode D is legal only when ALU_SEQ_MUL_EN is defined.
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  output logic [5:0] ctrl,
  output logic       legal
);

  always_comb begin
    ctrl  = op_ctrl(op);
    legal = (op <= OP_INCX);
`ifdef ALU_SEQ_MUL_EN
    if (op == OP_MUL) legal = 1'b1;
`endif
  end

endmodule

// File: rtl/alu_sequencer.sv
// Request/response controller driving an external Hack ALU; optional
// shift-add 16x16 multiply enabled by ALU_SEQ_MUL_EN.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [15:0] req_x,
  input  logic [15:0] req_y,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic        resp_zr,
  output logic        resp_ng,
  output logic        resp_err,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng
);

  state_t      state, state_nx;
  logic [15:0] x_q, y_q;
  logic [5:0]  ctrl_q;
  logic [5:0]  dec_ctrl;
  logic        dec_legal;
  logic [5:0]  alu_ctrl;

  alu_op_decode u_dec (
    .op    (req_op),
    .ctrl  (dec_ctrl),
    .legal (dec_legal)
  );

`ifdef ALU_SEQ_MUL_EN
  logic [15:0] acc, mcand, mplier, acc_nx;
  logic [3:0]  cnt;

  // ALU is wired as acc + mcand during MUL; keep the sum only on a 1 bit.
  assign acc_nx = mplier[0] ? alu_out : acc;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:
        if (req_valid) begin
          if (!dec_legal) state_nx = S_RESP;
`ifdef ALU_SEQ_MUL_EN
          else if (req_op == OP_MUL) state_nx = S_MUL;
`endif
          else state_nx = S_EXEC;
        end
      S_EXEC: state_nx = S_RESP;
      S_MUL: begin
`ifdef ALU_SEQ_MUL_EN
        if (cnt == 4'd15) state_nx = S_RESP;
`else
        state_nx = S_IDLE;
`endif
      end
      S_RESP: if (resp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ALU pins depend only on registered state, never on request inputs.
  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_RESP);
    alu_x      = 16'h0000;
    alu_y      = 16'h0000;
    alu_ctrl   = CW_ZERO;
    case (state)
      S_EXEC: begin
        alu_x    = x_q;
        alu_y    = y_q;
        alu_ctrl = ctrl_q;
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        alu_x    = acc;
        alu_y    = mcand;
        alu_ctrl = CW_ADD;
      end
`endif
      default: ;
    endcase
  end

  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = alu_ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      ctrl_q    <= '0;
      resp_data <= '0;
      resp_zr   <= 1'b0;
      resp_ng   <= 1'b0;
      resp_err  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE:
          if (req_valid) begin
            x_q    <= req_x;
            y_q    <= req_y;
            ctrl_q <= dec_ctrl;
            if (!dec_legal) begin
              resp_data <= '0;
              resp_zr   <= 1'b1;
              resp_ng   <= 1'b0;
              resp_err  <= 1'b1;
            end
`ifdef ALU_SEQ_MUL_EN
            acc    <= '0;
            mcand  <= req_x;
            mplier <= req_y;
            cnt    <= '0;
`endif
          end
        S_EXEC: begin
          resp_data <= alu_out;
          resp_zr   <= alu_zr;
          resp_ng   <= alu_ng;
          resp_err  <= 1'b0;
        end
`ifdef ALU_SEQ_MUL_EN
        S_MUL: begin
          acc    <= acc_nx;
          mcand  <= {mcand[14:0], 1'b0};
          mplier <= {1'b0, mplier[15:1]};
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            resp_data <= acc_nx;
            resp_zr   <= (acc_nx == 16'h0000);
            resp_ng   <= acc_nx[15];
            resp_err  <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
